// File: rtl/mul_stream_feeder.sv
// Operand feeder / result sink for the mul_dataflow accelerator: prefetches packed
// a/b pairs from memory, streams them out with one c beat, and captures d results.
module mul_stream_feeder #(
   parameter int MAC_CNT_LEN = 4096,
   parameter int ADDR_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                           ap_clk,
   input  logic                           ap_rst_n,
   input  logic                           start,
   input  logic [ADDR_WIDTH-1:0]          base_addr,
   input  logic [$clog2(MAC_CNT_LEN)-1:0] len,
   input  logic                           simple_mul,
   input  logic [31:0]                    c_value,
   output logic                           busy,
   output logic                           done,
   output logic                           mem_req,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   input  logic                           mem_gnt,
   input  logic                           mem_rvalid,
   input  logic [63:0]                    mem_rdata,
   output logic                           a_TVALID,
   input  logic                           a_TREADY,
   output logic [31:0]                    a_TDATA,
   output logic                           b_TVALID,
   input  logic                           b_TREADY,
   output logic [31:0]                    b_TDATA,
   output logic                           c_TVALID,
   input  logic                           c_TREADY,
   output logic [31:0]                    c_TDATA,
   input  logic                           d_TVALID,
   output logic                           d_TREADY,
   input  logic [31:0]                    d_TDATA,
   output logic                           res_valid,
   output logic [31:0]                    res_data
);
   localparam int LW  = $clog2(MAC_CNT_LEN);
   localparam int CW  = LW + 1;
   localparam int FAW = $clog2(FIFO_DEPTH);
   localparam logic [FAW+1:0] DEPTH_C = (FAW+2)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] base_q;
   logic [CW-1:0]         n_q, exp_q, issued_q, sent_q, recv_q, recv_d;
   logic [31:0]           c_val_q;
   logic                  c_sent_q;
   logic [FAW:0]          outst_q, cnt_q;
   logic [FAW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [63:0]           fifo_q [FIFO_DEPTH];
   logic                  res_valid_q;
   logic [31:0]           res_data_q;

   logic          run, grant, push, pop, c_fire, d_fire;
   logic [FAW+1:0] occ;

   assign run    = (state_q == S_RUN);
   assign grant  = mem_req & mem_gnt;
   assign push   = run & mem_rvalid;
   assign pop    = a_TVALID & a_TREADY & b_TREADY;
   assign c_fire = c_TVALID & c_TREADY;
   assign d_fire = d_TVALID & d_TREADY;

   // Reads in flight count against FIFO space so a push can never overflow.
   assign occ      = {1'b0, cnt_q} + {1'b0, outst_q};
   assign mem_req  = run & (issued_q < n_q) & (occ < DEPTH_C);
   assign mem_addr = base_q + (ADDR_WIDTH'(issued_q) << 3);

   assign a_TVALID  = run & (cnt_q != '0);
   assign b_TVALID  = a_TVALID;
   assign a_TDATA   = fifo_q[rd_ptr_q][31:0];
   assign b_TDATA   = fifo_q[rd_ptr_q][63:32];
   assign c_TVALID  = run & ~c_sent_q;
   assign c_TDATA   = c_val_q;
   assign d_TREADY  = (state_q == S_RUN) | (state_q == S_DRAIN);
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign recv_d    = recv_q + CW'(d_fire);

   always_comb begin
      state_d = state_q;
      busy    = (state_q != S_IDLE);
      done    = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         // A final d beat landing as RUN completes skips DRAIN.
         S_RUN:   if ((sent_q == n_q) && c_sent_q)
                     state_d = (recv_d == exp_q) ? S_DONE : S_DRAIN;
         S_DRAIN: if (recv_d == exp_q) state_d = S_DONE;
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         n_q         <= '0;
         exp_q       <= '0;
         issued_q    <= '0;
         sent_q      <= '0;
         recv_q      <= '0;
         c_val_q     <= '0;
         c_sent_q    <= 1'b0;
         outst_q     <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= d_fire;
         recv_q      <= recv_d;
         if (d_fire) res_data_q <= d_TDATA;
         if (state_q == S_IDLE) begin
            if (start) begin
               base_q   <= base_addr;
               n_q      <= CW'(len) + 1'b1;
               exp_q    <= simple_mul ? CW'(len) + 1'b1 : CW'(1);
               c_val_q  <= c_value;
               issued_q <= '0;
               sent_q   <= '0;
               recv_q   <= '0;
               c_sent_q <= 1'b0;
               outst_q  <= '0;
               cnt_q    <= '0;
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
            end
         end else begin
            if (grant) issued_q <= issued_q + 1'b1;
            case ({grant, push})
               2'b10:   outst_q <= outst_q + 1'b1;
               2'b01:   outst_q <= outst_q - 1'b1;
               default: ;
            endcase
            if (push) begin
               fifo_q[wr_ptr_q] <= mem_rdata;
               wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
               sent_q   <= sent_q + 1'b1;
            end
            case ({push, pop})
               2'b10:   cnt_q <= cnt_q + 1'b1;
               2'b01:   cnt_q <= cnt_q - 1'b1;
               default: ;
            endcase
            if (c_fire) c_sent_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mul_stream_feeder.sv
// Bench for mul_stream_feeder: memory, accelerator and result model driven each
// negedge, end-to-end checks against operand tables.
module tb_mul_stream_feeder;
   localparam int FD = 4;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n, start, simple_mul;
   logic [31:0] base_addr, c_value;
   logic [11:0] len;
   logic        busy, done, mem_req, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr;
   logic [63:0] mem_rdata;
   logic        a_TVALID, a_TREADY, b_TVALID, b_TREADY, c_TVALID, c_TREADY;
   logic        d_TVALID, d_TREADY, res_valid;
   logic [31:0] a_TDATA, b_TDATA, c_TDATA, d_TDATA, res_data;

   mul_stream_feeder #(.MAC_CNT_LEN(4096), .ADDR_WIDTH(32), .FIFO_DEPTH(FD)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .base_addr(base_addr),
      .len(len), .simple_mul(simple_mul), .c_value(c_value), .busy(busy), .done(done),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .a_TVALID(a_TVALID), .a_TREADY(a_TREADY), .a_TDATA(a_TDATA),
      .b_TVALID(b_TVALID), .b_TREADY(b_TREADY), .b_TDATA(b_TDATA), .c_TVALID(c_TVALID),
      .c_TREADY(c_TREADY), .c_TDATA(c_TDATA), .d_TVALID(d_TVALID), .d_TREADY(d_TREADY),
      .d_TDATA(d_TDATA), .res_valid(res_valid), .res_data(res_data));

   always #5 ap_clk = ~ap_clk;

   logic [63:0] mem_img [4096];
   logic [63:0] pend[$];
   logic [63:0] ab_log[$];
   logic [31:0] addr_log[$], c_log[$], res_log[$], dq[$];
   int          dq_t[$];
   int          n_vec = 0, n_err = 0, cyc_no = 0;
   int          beats, granted, done_cnt, gnt_wait, cur_n;
   int          gnt_max = 0, rv_pct = 100, ab_pct = 100, c_pct = 100;
   logic [31:0] cur_base, acc;
   logic        cur_simple;
   logic        ab_hold = 1'b0;
   logic [63:0] ab_prev = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of environment: sample last edge's results, then drive the next edge.
   task automatic env();
      logic [31:0] off, prod;
      logic        fire;
      cyc_no++;
      if (ab_hold) begin
         chk("ab_valid_hold", 64'(a_TVALID), 64'(1));
         chk("ab_data_hold", {b_TDATA, a_TDATA}, ab_prev);
      end
      chk("ab_valid_pair", 64'(b_TVALID), 64'(a_TVALID));
      if (res_valid) res_log.push_back(res_data);
      if (done) done_cnt++;
      if (busy) chk("fifo_bound", 64'((granted - beats) <= FD), 64'(1));

      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (pend.size() != 0 && $urandom_range(99) < rv_pct) begin
         mem_rvalid = 1'b1;
         mem_rdata  = pend.pop_front();
      end
      mem_gnt = 1'b0;
      if (mem_req && ap_rst_n) begin
         if (gnt_wait == 0) begin
            mem_gnt = 1'b1;
            off = mem_addr - cur_base;
            addr_log.push_back(mem_addr);
            pend.push_back(mem_img[off[14:3]]);
            granted++;
            gnt_wait = $urandom_range(gnt_max);
         end else gnt_wait--;
      end

      a_TREADY = ($urandom_range(99) < ab_pct);
      b_TREADY = ($urandom_range(99) < ab_pct);
      fire     = ap_rst_n && a_TVALID && a_TREADY && b_TREADY;
      ab_hold  = ap_rst_n && a_TVALID && !fire;
      ab_prev  = {b_TDATA, a_TDATA};
      if (fire) begin
         ab_log.push_back(ab_prev);
         beats++;
         prod = a_TDATA * b_TDATA;
         if (cur_simple) begin
            dq.push_back(prod);
            dq_t.push_back(cyc_no + 2);
         end else begin
            acc = acc + prod;
            if (beats == cur_n) begin
               dq.push_back(acc);
               dq_t.push_back(cyc_no + 2);
            end
         end
      end

      c_TREADY = ($urandom_range(99) < c_pct);
      if (ap_rst_n && c_TVALID && c_TREADY) c_log.push_back(c_TDATA);

      d_TVALID = 1'b0;
      d_TDATA  = $urandom;
      if (dq.size() != 0 && dq_t[0] <= cyc_no) begin
         d_TVALID = 1'b1;
         d_TDATA  = dq[0];
         if (d_TREADY && ap_rst_n) begin
            void'(dq.pop_front());
            void'(dq_t.pop_front());
         end
      end
   endtask

   task automatic cyc();
      @(negedge ap_clk);
      env();
   endtask

   task automatic clr_model(input logic [31:0] base, input int n, input logic simple);
      pend.delete(); ab_log.delete(); addr_log.delete(); c_log.delete();
      res_log.delete(); dq.delete(); dq_t.delete();
      beats = 0; granted = 0; done_cnt = 0; gnt_wait = 0; acc = '0;
      cur_base = base; cur_n = n; cur_simple = simple;
   endtask

   task automatic fill_random(input int n);
      for (int k = 0; k < n; k++) mem_img[k] = {$urandom, $urandom};
   endtask

   task automatic pulse_start(input logic [31:0] base, input int ln, input logic simple,
                              input logic [31:0] cval);
      logic [31:0] l32;
      l32 = ln;
      clr_model(base, ln + 1, simple);
      start = 1'b1; base_addr = base; len = l32[11:0]; simple_mul = simple; c_value = cval;
      cyc();
      start = 1'b0; base_addr = $urandom; len = 12'($urandom); simple_mul = ~simple;
      c_value = $urandom;
      chk("busy_after_start", 64'(busy), 64'(1));
   endtask

   task automatic run_job(input logic [31:0] base, input int ln, input logic simple,
                          input logic [31:0] cval, input logic xstart);
      logic        seen;
      logic [31:0] pa, pb, e, s;
      int          nres;
      pulse_start(base, ln, simple, cval);
      seen = 1'b0;
      for (int i = 0; i < 20000 && !seen; i++) begin
         start = xstart && (i == 3);
         cyc();
         if (done) seen = 1'b1;
      end
      chk("done_seen", 64'(seen), 64'(1));
      start = xstart;
      cyc();
      start = 1'b0;
      chk("busy_fall", 64'(busy), 64'(0));
      cyc(); cyc();
      chk("done_once", 64'(done_cnt), 64'(1));
      chk("idle_after", 64'(busy), 64'(0));

      chk("ab_beats", 64'(ab_log.size()), 64'(cur_n));
      for (int k = 0; k < ab_log.size() && k < cur_n; k++)
         chk("ab_pair", ab_log[k], mem_img[k]);
      chk("reads", 64'(addr_log.size()), 64'(cur_n));
      for (int k = 0; k < addr_log.size(); k++)
         chk("rd_addr", 64'(addr_log[k]), 64'(base + 32'(8 * k)));
      chk("c_beats", 64'(c_log.size()), 64'(1));
      if (c_log.size() > 0) chk("c_data", 64'(c_log[0]), 64'(cval));

      nres = simple ? cur_n : 1;
      chk("res_cnt", 64'(res_log.size()), 64'(nres));
      s = '0;
      for (int k = 0; k < cur_n; k++) begin
         pa = mem_img[k][31:0];
         pb = mem_img[k][63:32];
         e  = pa * pb;
         s  = s + e;
         if (simple && k < res_log.size()) chk("res_simple", 64'(res_log[k]), 64'(e));
      end
      if (!simple && res_log.size() > 0) chk("res_mac", 64'(res_log[0]), 64'(s));
   endtask

   initial begin
      logic ok;
      ap_rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; simple_mul = 1'b0;
      c_value = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      a_TREADY = 1'b0; b_TREADY = 1'b0; c_TREADY = 1'b0; d_TVALID = 1'b0; d_TDATA = '0;
      clr_model(32'h0, 1, 1'b1);
      repeat (3) cyc();
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_a_valid", 64'(a_TVALID), 64'(0));
      chk("rst_c_valid", 64'(c_TVALID), 64'(0));
      chk("rst_d_ready", 64'(d_TREADY), 64'(0));
      chk("rst_res_valid", 64'(res_valid), 64'(0));
      chk("rst_res_data", 64'(res_data), 64'(0));
      ap_rst_n = 1'b1;
      cyc();

      // simple mode, word k = {b=k+1, a=k+2}
      for (int k = 0; k < 4; k++) mem_img[k] = {32'(k + 1), 32'(k + 2)};
      run_job(32'h100, 3, 1'b1, 32'h55, 1'b0);

      // MAC, a=7 b=-3 -> -21
      mem_img[0] = {32'hFFFF_FFFD, 32'd7};
      run_job(32'h40, 0, 1'b0, 32'd5, 1'b0);
      if (res_log.size() > 0) chk("mac_minus21", 64'(res_log[0]), 64'(32'hFFFF_FFEB));

      // backpressure
      fill_random(16);
      gnt_max = 3; rv_pct = 60; ab_pct = 50; c_pct = 50;
      run_job(32'h1000, 15, 1'b1, $urandom, 1'b0);

      // random jobs, first one with start pulses during RUN and DONE
      fill_random(24);
      gnt_max = 2; rv_pct = 70; ab_pct = 60; c_pct = 30;
      run_job(32'h2008, 12, 1'b0, $urandom, 1'b1);
      fill_random(24);
      gnt_max = $urandom_range(3); rv_pct = 50; ab_pct = 80; c_pct = 70;
      run_job(32'h3000, $urandom_range(1, 20), 1'($urandom_range(1)), $urandom, 1'b1);

      // maximum length in MAC mode
      fill_random(4096);
      gnt_max = 0; rv_pct = 100; ab_pct = 100; c_pct = 100;
      run_job(32'h8000, 4095, 1'b0, $urandom, 1'b0);

      // reset mid-job with reads in flight
      fill_random(16);
      rv_pct = 15;
      pulse_start(32'h2000, 15, 1'b1, $urandom);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         cyc();
         if (beats >= 5 && pend.size() >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rst_setup", 64'(ok), 64'(1));
      ap_rst_n = 1'b0;
      cyc();
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_mem_req", 64'(mem_req), 64'(0));
      chk("mid_rst_ab_valid", 64'(a_TVALID | b_TVALID), 64'(0));
      chk("mid_rst_c_valid", 64'(c_TVALID), 64'(0));
      chk("mid_rst_d_ready", 64'(d_TREADY), 64'(0));
      chk("mid_rst_res", 64'({res_valid, res_data}), 64'(0));
      ap_rst_n = 1'b1;
      rv_pct = 100;
      for (int i = 0; i < 50 && pend.size() != 0; i++) cyc();
      chk("late_rv_drained", 64'(pend.size()), 64'(0));
      repeat (3) cyc();
      chk("late_rv_idle", 64'({busy, mem_req, a_TVALID, res_valid}), 64'(0));
      fill_random(2);
      run_job(32'h300, 1, 1'b1, $urandom, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
